vx_barrier_ctl: RTL and testbench

- Consumer of the warp-control bus on the barrier path, inside the scheduler; sits directly downstream of the wctl execute unit.
- Tracks warp arrivals at each hardware barrier and holds arriving warps stalled.
- Emits a one-cycle release pulse with the warp mask once the programmed warp count has arrived.
- Scheduler ORs stalled_mask into its warp-stall vector and clears stalls on release.

---
 rtl/vx_barrier_ctl_pkg.sv | 26 ++
 rtl/vx_barrier_slot.sv | 87 ++++++++
 rtl/vx_barrier_ctl.sv | 119 +++++++++++
 tb/tb_vx_barrier_ctl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/vx_barrier_ctl_pkg.sv
// Shared types and constants for the barrier controller.
// The request struct is sized from the default build configuration below.
package vx_barrier_ctl_pkg;

    localparam int VX_NUM_WARPS    = 4;
    localparam int VX_NUM_BARRIERS = 4;

    function automatic int nb_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int VX_NW_WIDTH = $clog2(VX_NUM_WARPS);
    localparam int VX_NB_WIDTH = nb_width(VX_NUM_BARRIERS);

    typedef struct packed {
        logic                   valid;
        logic [VX_NB_WIDTH-1:0] id;
        logic [VX_NW_WIDTH-1:0] size_m1;
    } barrier_req_t;

    typedef enum logic {
        BAR_IDLE,
        BAR_FILLING
    } bar_state_e;

endpackage

// File: rtl/vx_barrier_slot.sv
// One hardware barrier: counts arrivals, holds the waiting-warp mask and
// reports a release (combinational) on the arrival that completes it.
//
// state       | meaning
// BAR_IDLE    | no warp waiting; next arrival latches the barrier size
// BAR_FILLING | at least one warp waiting; count/mask/size valid
module vx_barrier_slot
    import vx_barrier_ctl_pkg::*;
#(
    parameter int NUM_WARPS = VX_NUM_WARPS,
    parameter int NW_WIDTH  = $clog2(NUM_WARPS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_arrive,
    input  logic [NW_WIDTH-1:0]  i_wid,
    input  logic [NW_WIDTH-1:0]  i_size_m1,
    output logic                 o_release,
    output logic [NUM_WARPS-1:0] o_release_mask,
    output logic [NUM_WARPS-1:0] o_mask
);

    bar_state_e            r_state, w_state_nxt;
    logic [NW_WIDTH-1:0]   r_count, w_count_nxt;
    logic [NW_WIDTH-1:0]   r_size,  w_size_nxt;
    logic [NUM_WARPS-1:0]  r_mask,  w_mask_nxt;
    logic [NUM_WARPS-1:0]  w_bit;

    assign w_bit  = NUM_WARPS'(1) << i_wid;
    assign o_mask = r_mask;

    // Slot state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= BAR_IDLE;
            r_count <= '0;
            r_size  <= '0;
            r_mask  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_size  <= w_size_nxt;
            r_mask  <= w_mask_nxt;
        end
    end

    // Next-state and release decision for one arrival.
    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_size_nxt     = r_size;
        w_mask_nxt     = r_mask;
        o_release      = 1'b0;
        o_release_mask = '0;
        if (i_arrive) begin
            case (r_state)
                BAR_IDLE: begin
                    if (i_size_m1 == '0) begin
                        // Single-warp barrier: release at once, never stalls.
                        o_release      = 1'b1;
                        o_release_mask = w_bit;
                    end else begin
                        w_state_nxt = BAR_FILLING;
                        w_size_nxt  = i_size_m1;
                        w_count_nxt = NW_WIDTH'(1);
                        w_mask_nxt  = w_bit;
                    end
                end
                BAR_FILLING: begin
                    if (r_count == r_size) begin
                        o_release      = 1'b1;
                        o_release_mask = r_mask | w_bit;
                        w_state_nxt    = BAR_IDLE;
                        w_count_nxt    = '0;
                        w_size_nxt     = '0;
                        w_mask_nxt     = '0;
                    end else begin
                        w_count_nxt = r_count + NW_WIDTH'(1);
                        w_mask_nxt  = r_mask | w_bit;
                    end
                end
                default: w_state_nxt = BAR_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/vx_barrier_ctl.sv
// Barrier controller on the warp-control bus: decodes barrier ops to
// per-barrier slots, exposes the stalled-warp vector and registers a
// one-cycle release pulse. Optional stall-cycle counter: VX_BARRIER_PERF_EN.
module vx_barrier_ctl
    import vx_barrier_ctl_pkg::*;
#(
    parameter int NUM_WARPS    = VX_NUM_WARPS,
    parameter int NUM_BARRIERS = VX_NUM_BARRIERS,
    parameter int NW_WIDTH     = $clog2(NUM_WARPS),
    parameter int NB_WIDTH     = nb_width(NUM_BARRIERS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ctl_valid,
    input  logic [NW_WIDTH-1:0]  ctl_wid,
    input  logic                 bar_valid,
    input  logic [NB_WIDTH-1:0]  bar_id,
    input  logic [NW_WIDTH-1:0]  bar_size_m1,
    output logic [NUM_WARPS-1:0] stalled_mask,
    output logic                 release_valid,
    output logic [NB_WIDTH-1:0]  release_id,
    output logic [NUM_WARPS-1:0] release_mask
`ifdef VX_BARRIER_PERF_EN
    ,
    output logic [63:0]          perf_stall_cycles
`endif
);

    barrier_req_t          w_req;
    logic                  w_dup;
    logic                  w_accept;
    logic                  w_slot_rel   [NUM_BARRIERS];
    logic [NUM_WARPS-1:0]  w_slot_rmask [NUM_BARRIERS];
    logic [NUM_WARPS-1:0]  w_slot_mask  [NUM_BARRIERS];
    logic                  w_rel_any;
    logic [NUM_WARPS-1:0]  w_rel_mask;
    logic                  r_release_valid;
    logic [NB_WIDTH-1:0]   r_release_id;
    logic [NUM_WARPS-1:0]  r_release_mask;

    assign w_req.valid   = ctl_valid & bar_valid;
    assign w_req.id      = bar_id;
    assign w_req.size_m1 = bar_size_m1;

    // A warp already waiting somewhere cannot arrive again; drop it.
    assign w_dup    = w_req.valid & stalled_mask[ctl_wid];
    assign w_accept = w_req.valid & ~w_dup;

    for (genvar g = 0; g < NUM_BARRIERS; g++) begin : g_slot
        vx_barrier_slot #(
            .NUM_WARPS (NUM_WARPS),
            .NW_WIDTH  (NW_WIDTH)
        ) u_slot (
            .clk            (clk),
            .reset          (reset),
            .i_arrive       (w_accept && (w_req.id == NB_WIDTH'(g))),
            .i_wid          (ctl_wid),
            .i_size_m1      (w_req.size_m1),
            .o_release      (w_slot_rel[g]),
            .o_release_mask (w_slot_rmask[g]),
            .o_mask         (w_slot_mask[g])
        );
    end

    // Merge slot views; only the addressed slot can release in a cycle.
    always_comb begin
        stalled_mask = '0;
        w_rel_any    = 1'b0;
        w_rel_mask   = '0;
        for (int i = 0; i < NUM_BARRIERS; i++) begin
            stalled_mask = stalled_mask | w_slot_mask[i];
            w_rel_any    = w_rel_any | w_slot_rel[i];
            w_rel_mask   = w_rel_mask | w_slot_rmask[i];
        end
    end

    // Release pulse register; outputs are zero whenever no release.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_release_valid <= 1'b0;
            r_release_id    <= '0;
            r_release_mask  <= '0;
        end else begin
            r_release_valid <= w_rel_any;
            r_release_id    <= w_rel_any ? w_req.id : '0;
            r_release_mask  <= w_rel_mask;
        end
    end

    assign release_valid = r_release_valid;
    assign release_id    = r_release_id;
    assign release_mask  = r_release_mask;

`ifdef VX_BARRIER_PERF_EN
    logic [63:0] r_perf_stall;

    // Accumulate warp-cycles spent waiting at barriers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_stall <= '0;
        end else begin
            r_perf_stall <= r_perf_stall + 64'($countones(stalled_mask));
        end
    end

    assign perf_stall_cycles = r_perf_stall;
`endif

`ifndef SYNTHESIS
    // Flag a warp arriving while it is still parked at a barrier.
    always @(posedge clk) begin
        if (!reset) begin
            a_no_dup_arrival: assert (!w_dup)
                else $warning("duplicate barrier arrival ignored: warp %0d", ctl_wid);
        end
    end
`endif

endmodule

// File: tb/tb_vx_barrier_ctl.sv
module tb_vx_barrier_ctl;

    logic       clk;
    logic       reset;
    logic       ctl_valid;
    logic [1:0] ctl_wid;
    logic       bar_valid;
    logic [1:0] bar_id;
    logic [1:0] bar_size_m1;
    logic [3:0] stalled_mask;
    logic       release_valid;
    logic [1:0] release_id;
    logic [3:0] release_mask;
`ifdef VX_BARRIER_PERF_EN
    logic [63:0] perf_stall_cycles;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    vx_barrier_ctl dut (
        .clk           (clk),
        .reset         (reset),
        .ctl_valid     (ctl_valid),
        .ctl_wid       (ctl_wid),
        .bar_valid     (bar_valid),
        .bar_id        (bar_id),
        .bar_size_m1   (bar_size_m1),
        .stalled_mask  (stalled_mask),
        .release_valid (release_valid),
        .release_id    (release_id),
        .release_mask  (release_mask)
`ifdef VX_BARRIER_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       cv;
        logic       bv;
        logic [1:0] wid;
        logic [1:0] bid;
        logic [1:0] sz;
        logic [3:0] stl;
        logic       rv;
        logic [1:0] rid;
        logic [3:0] rm;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] stl, input logic rv,
                              input logic [1:0] rid, input logic [3:0] rm);
        check({tag, ".stalled_mask"}, 64'(stalled_mask), 64'(stl));
        check({tag, ".release_valid"}, 64'(release_valid), 64'(rv));
        check({tag, ".release_id"}, 64'(release_id), 64'(rid));
        check({tag, ".release_mask"}, 64'(release_mask), 64'(rm));
    endtask

    // Drive one bus cycle, then sample just after the capturing edge.
    task automatic step(input logic cv, input logic bv, input logic [1:0] wid,
                        input logic [1:0] bid, input logic [1:0] sz);
        ctl_valid   = cv;
        bar_valid   = bv;
        ctl_wid     = wid;
        bar_id      = bid;
        bar_size_m1 = sz;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // cv bv wid bid sz | stalled rv rid rmask
        // barrier 1, four warps
        vecs.push_back('{1, 1, 2'd0, 2'd1, 2'd3, 4'b0001, 0, 2'd0, 4'b0000});
        vecs.push_back('{1, 1, 2'd1, 2'd1, 2'd3, 4'b0011, 0, 2'd0, 4'b0000});
        vecs.push_back('{1, 1, 2'd2, 2'd1, 2'd3, 4'b0111, 0, 2'd0, 4'b0000});
        vecs.push_back('{1, 1, 2'd3, 2'd1, 2'd3, 4'b0000, 1, 2'd1, 4'b1111});
        vecs.push_back('{0, 0, 2'd0, 2'd0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000});
        // single-warp barrier
        vecs.push_back('{1, 1, 2'd2, 2'd0, 2'd0, 4'b0000, 1, 2'd0, 4'b0100});
        vecs.push_back('{0, 0, 2'd0, 2'd0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000});
        // interleaved barriers; later size_m1 values ignored
        vecs.push_back('{1, 1, 2'd0, 2'd0, 2'd1, 4'b0001, 0, 2'd0, 4'b0000});
        vecs.push_back('{1, 1, 2'd1, 2'd1, 2'd1, 4'b0011, 0, 2'd0, 4'b0000});
        vecs.push_back('{1, 1, 2'd2, 2'd0, 2'd3, 4'b0010, 1, 2'd0, 4'b0101});
        vecs.push_back('{1, 1, 2'd3, 2'd1, 2'd0, 4'b0000, 1, 2'd1, 4'b1010});
        // bar_valid without ctl_valid and vice versa: no effect
        vecs.push_back('{1, 0, 2'd0, 2'd2, 2'd0, 4'b0000, 0, 2'd0, 4'b0000});
        vecs.push_back('{0, 1, 2'd0, 2'd2, 2'd0, 4'b0000, 0, 2'd0, 4'b0000});
        // duplicate arrival of warp 1 at barrier 2 is dropped
        vecs.push_back('{1, 1, 2'd1, 2'd2, 2'd2, 4'b0010, 0, 2'd0, 4'b0000});
        vecs.push_back('{1, 1, 2'd1, 2'd2, 2'd2, 4'b0010, 0, 2'd0, 4'b0000});
        vecs.push_back('{1, 1, 2'd0, 2'd2, 2'd2, 4'b0011, 0, 2'd0, 4'b0000});
        vecs.push_back('{1, 1, 2'd3, 2'd2, 2'd2, 4'b0000, 1, 2'd2, 4'b1011});
        vecs.push_back('{0, 0, 2'd0, 2'd0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000});

        ctl_valid = 0; bar_valid = 0; ctl_wid = 0; bar_id = 0; bar_size_m1 = 0;
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_outs("reset", 4'b0000, 1'b0, 2'd0, 4'b0000);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].cv, vecs[i].bv, vecs[i].wid, vecs[i].bid, vecs[i].sz);
            check_outs($sformatf("vec%0d", i), vecs[i].stl, vecs[i].rv, vecs[i].rid, vecs[i].rm);
        end

        // Reset mid-fill on barrier 3 drops the waiting warps silently.
        step(1, 1, 2'd0, 2'd3, 2'd2);
        step(1, 1, 2'd1, 2'd3, 2'd2);
        check_outs("fill3", 4'b0011, 1'b0, 2'd0, 4'b0000);
        reset = 1'b1;
        step(0, 0, 2'd0, 2'd0, 2'd0);
        reset = 1'b0;
        check_outs("rst_mid", 4'b0000, 1'b0, 2'd0, 4'b0000);
        step(1, 1, 2'd2, 2'd3, 2'd1);
        check_outs("refill1", 4'b0100, 1'b0, 2'd0, 4'b0000);
        step(1, 1, 2'd0, 2'd3, 2'd3);
        check_outs("refill2", 4'b0000, 1'b1, 2'd3, 4'b0101);

        // Reset beats a completing arrival in the same cycle.
        step(1, 1, 2'd1, 2'd3, 2'd1);
        check_outs("pre_rst", 4'b0010, 1'b0, 2'd0, 4'b0000);
        reset = 1'b1;
        step(1, 1, 2'd2, 2'd3, 2'd1);
        reset = 1'b0;
        check_outs("rst_vs_rel", 4'b0000, 1'b0, 2'd0, 4'b0000);
        step(0, 0, 2'd0, 2'd0, 2'd0);
        check_outs("post_rst", 4'b0000, 1'b0, 2'd0, 4'b0000);

`ifdef VX_BARRIER_PERF_EN
        begin
            logic [63:0] p0;
            check("perf_after_reset", perf_stall_cycles, 64'd0);
            step(1, 1, 2'd0, 2'd0, 2'd3);
            step(1, 1, 2'd1, 2'd0, 2'd3);
            check_outs("perf_fill", 4'b0011, 1'b0, 2'd0, 4'b0000);
            p0 = perf_stall_cycles;
            for (int k = 0; k < 5; k++) step(0, 0, 2'd0, 2'd0, 2'd0);
            check("perf_delta", perf_stall_cycles - p0, 64'd10);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
